// File: rtl/wb_commit_if.sv
// Purpose: groups the writeback-commit bus (instruction fields, GPR reads, state, store drain).
// Latency: pure wiring, no logic.
// Backpressure: stall (toward writeback) and mem_ack (from memory) travel through here.
interface wb_commit_if;
  // writeback-stage instruction
  logic        v;
  logic        rfwe;
  logic [2:0]  drid;
  logic [31:0] rfval;
  logic [31:0] ccwe;
  logic [31:0] cc;
  logic        eipwe;
  logic [31:0] eipval;
  logic        cswe;
  logic [15:0] csval;
  logic        mwe;
  logic [31:0] maddr;
  logic [31:0] mdata;
  logic        stall;
  // store drain
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack;
  // GPR read ports
  logic [2:0]  rd_id0;
  logic [2:0]  rd_id1;
  logic [31:0] rd_val0;
  logic [31:0] rd_val1;
  // architectural state
  logic [31:0] eflags;
  logic [31:0] eip;
  logic [15:0] cs;
  logic        sb_empty;

  // Writeback stage / memory / readers side.
  modport master (
    output v, rfwe, drid, rfval, ccwe, cc, eipwe, eipval, cswe, csval,
           mwe, maddr, mdata, mem_ack, rd_id0, rd_id1,
    input  stall, mem_req, mem_addr, mem_data, rd_val0, rd_val1,
           eflags, eip, cs, sb_empty
  );

  // Commit unit side.
  modport slave (
    input  v, rfwe, drid, rfval, ccwe, cc, eipwe, eipval, cswe, csval,
           mwe, maddr, mdata, mem_ack, rd_id0, rd_id1,
    output stall, mem_req, mem_addr, mem_data, rd_val0, rd_val1,
           eflags, eip, cs, sb_empty
  );
endinterface

// File: rtl/wb_commit.sv
// Purpose: commits writeback results to GPRs/EFLAGS/EIP/CS and queues stores in a drain buffer.
// Latency: state visible the cycle after commit; a store into an empty buffer raises mem_req next cycle.
// Backpressure: stall when a store meets a full buffer (a same-cycle ack does not help); drain waits on mem_ack.
module wb_commit #(
  parameter int          SB_DEPTH  = 2,
  parameter logic [31:0] RESET_EIP = 32'h0000FFF0
) (
  input logic         clk,
  input logic         reset_n,
  wb_commit_if.slave  bus
);

  localparam int PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   r_gpr [8];
  logic [31:0]   r_eflags;
  logic [31:0]   r_eip;
  logic [15:0]   r_cs;

  logic [31:0]   r_sb_addr [SB_DEPTH];
  logic [31:0]   r_sb_data [SB_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_stall;
  logic          w_commit;
  logic          w_push;
  logic          w_pop;

  // Buffer status comes only from registered occupancy so it never sees same-cycle acks.
  always_comb begin
    w_full   = (r_count == CW'(SB_DEPTH));
    w_empty  = (r_count == '0);
    w_stall  = bus.v & bus.mwe & w_full;
    w_commit = bus.v & ~w_stall;
    w_push   = w_commit & bus.mwe;
    w_pop    = ~w_empty & bus.mem_ack;
  end

  assign bus.stall    = w_stall;
  assign bus.mem_req  = ~w_empty;
  assign bus.mem_addr = r_sb_addr[r_rd_ptr];
  assign bus.mem_data = r_sb_data[r_rd_ptr];
  assign bus.sb_empty = w_empty;
  assign bus.rd_val0  = r_gpr[bus.rd_id0];
  assign bus.rd_val1  = r_gpr[bus.rd_id1];
  assign bus.eflags   = r_eflags;
  assign bus.eip      = r_eip;
  assign bus.cs       = r_cs;

  // Architectural state: reset wins over commit; a stalled instruction changes nothing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) r_gpr[i] <= '0;
      r_eflags <= 32'h0000_0002;
      r_eip    <= RESET_EIP;
      r_cs     <= 16'hF000;
    end else if (w_commit) begin
      if (bus.rfwe)  r_gpr[bus.drid] <= bus.rfval;
      // Bit 1 of EFLAGS is architecturally reserved as 1.
      r_eflags <= (r_eflags & ~bus.ccwe) | (bus.cc & bus.ccwe) | 32'h0000_0002;
      if (bus.eipwe) r_eip <= bus.eipval;
      if (bus.cswe)  r_cs  <= bus.csval;
    end
  end

  // Store buffer pointers and occupancy; reset drops pending stores even if acked that cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Store buffer payload; contents are meaningless while empty, so no reset is needed.
  always_ff @(posedge clk) begin
    if (reset_n && w_push) begin
      r_sb_addr[r_wr_ptr] <= bus.maddr;
      r_sb_data[r_wr_ptr] <= bus.mdata;
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// Purpose: directed self-checking bench for wb_commit with SB_DEPTH=2.
// Latency: inputs change 1 time unit after a rising edge, outputs checked in the same window.
// Backpressure: exercises full-buffer stall, ack-driven drain and reset mid-drain.
module tb_wb_commit;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  wb_commit_if bus ();

  wb_commit #(.SB_DEPTH(2), .RESET_EIP(32'h0000FFF0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.v = 1'b0; bus.rfwe = 1'b0; bus.drid = 3'd0; bus.rfval = '0;
    bus.ccwe = '0; bus.cc = '0; bus.eipwe = 1'b0; bus.eipval = '0;
    bus.cswe = 1'b0; bus.csval = '0; bus.mwe = 1'b0; bus.maddr = '0; bus.mdata = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    bus.mem_ack = 1'b0;
    bus.rd_id0 = 3'd0;
    bus.rd_id1 = 3'd0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst_mem_req",  32'(bus.mem_req), 32'd0);
    chk("rst_sb_empty", 32'(bus.sb_empty), 32'd1);
    chk("rst_stall",    32'(bus.stall), 32'd0);
    chk("rst_eflags",   bus.eflags, 32'h0000_0002);
    chk("rst_eip",      bus.eip, 32'h0000_FFF0);
    chk("rst_cs",       32'(bus.cs), 32'h0000_F000);
    chk("rst_gpr0",     bus.rd_val0, 32'd0);

    // GPR write, visible next cycle; all other GPRs untouched
    bus.v = 1'b1; bus.rfwe = 1'b1; bus.drid = 3'd3; bus.rfval = 32'hDEAD_BEEF;
    bus.rd_id0 = 3'd3;
    #1;
    chk("gpr_no_bypass", bus.rd_val0, 32'd0);
    tick();
    idle();
    #1;
    chk("gpr3_write", bus.rd_val0, 32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) begin
      if (i != 3) begin
        bus.rd_id1 = 3'(i);
        #1;
        chk($sformatf("gpr%0d_zero", i), bus.rd_val1, 32'd0);
      end
    end

    // EFLAGS masked merge, then clearing everything still leaves bit 1
    bus.v = 1'b1; bus.ccwe = 32'h0000_08D5; bus.cc = 32'hFFFF_FFFF;
    tick();
    chk("eflags_merge", bus.eflags, 32'h0000_08D7);
    bus.ccwe = 32'hFFFF_FFFF; bus.cc = 32'h0000_0000;
    tick();
    chk("eflags_bit1", bus.eflags, 32'h0000_0002);

    // EIP and CS loads
    idle();
    bus.v = 1'b1; bus.eipwe = 1'b1; bus.eipval = 32'h0000_1234;
    bus.cswe = 1'b1; bus.csval = 16'h0008;
    tick();
    chk("eip_load", bus.eip, 32'h0000_1234);
    chk("cs_load",  32'(bus.cs), 32'h0000_0008);

    // v=0 with every enable set: nothing changes, nothing is pushed
    bus.v = 1'b0; bus.rfwe = 1'b1; bus.drid = 3'd3; bus.rfval = 32'h0;
    bus.ccwe = 32'hFFFF_FFFF; bus.cc = 32'hFFFF_FFFF;
    bus.eipwe = 1'b1; bus.eipval = 32'h0; bus.cswe = 1'b1; bus.csval = 16'h0;
    bus.mwe = 1'b1; bus.maddr = 32'h0000_0999; bus.mdata = 32'h9;
    tick();
    bus.rd_id0 = 3'd3;
    #1;
    chk("v0_gpr",      bus.rd_val0, 32'hDEAD_BEEF);
    chk("v0_eflags",   bus.eflags, 32'h0000_0002);
    chk("v0_eip",      bus.eip, 32'h0000_1234);
    chk("v0_cs",       32'(bus.cs), 32'h0000_0008);
    chk("v0_sb_empty", 32'(bus.sb_empty), 32'd1);
    chk("v0_mem_req",  32'(bus.mem_req), 32'd0);

    // Fill the buffer with ack held low
    idle();
    bus.v = 1'b1; bus.mwe = 1'b1; bus.maddr = 32'h0000_0100; bus.mdata = 32'h0000_0011;
    #1;
    chk("push1_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("push1_mem_req",  32'(bus.mem_req), 32'd1);
    chk("push1_mem_addr", bus.mem_addr, 32'h0000_0100);
    chk("push1_mem_data", bus.mem_data, 32'h0000_0011);
    bus.maddr = 32'h0000_0200; bus.mdata = 32'h0000_0022;
    tick();
    chk("push2_mem_addr", bus.mem_addr, 32'h0000_0100);
    bus.maddr = 32'h0000_0300; bus.mdata = 32'h0000_0033;
    bus.rfwe = 1'b1; bus.drid = 3'd5; bus.rfval = 32'h5555_5555;
    bus.rd_id0 = 3'd5;
    #1;
    chk("full_stall", 32'(bus.stall), 32'd1);
    tick();
    chk("held_stall",    32'(bus.stall), 32'd1);
    chk("held_no_gpr",   bus.rd_val0, 32'd0);
    chk("held_mem_addr", bus.mem_addr, 32'h0000_0100);

    // One ack while full: stall persists this cycle, drops next
    bus.mem_ack = 1'b1;
    #1;
    chk("ack_same_cycle_stall", 32'(bus.stall), 32'd1);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("pop_head_a2",   bus.mem_addr, 32'h0000_0200);
    chk("pop_head_d2",   bus.mem_data, 32'h0000_0022);
    chk("pop_stall_low", 32'(bus.stall), 32'd0);
    tick();
    idle();
    #1;
    chk("third_gpr",  bus.rd_val0, 32'h5555_5555);
    chk("third_head", bus.mem_addr, 32'h0000_0200);
    bus.mem_ack = 1'b1;
    tick();
    chk("drain_a3", bus.mem_addr, 32'h0000_0300);
    chk("drain_d3", bus.mem_data, 32'h0000_0033);
    tick();
    chk("drained_empty", 32'(bus.sb_empty), 32'd1);
    chk("drained_req",   32'(bus.mem_req), 32'd0);
    tick();
    chk("ack_empty_ignored", 32'(bus.sb_empty), 32'd1);

    // Simultaneous push and pop keeps occupancy and order
    bus.mem_ack = 1'b0;
    bus.v = 1'b1; bus.mwe = 1'b1; bus.maddr = 32'h0000_0400; bus.mdata = 32'h0000_0044;
    tick();
    bus.maddr = 32'h0000_0500; bus.mdata = 32'h0000_0055;
    bus.mem_ack = 1'b1;
    tick();
    idle();
    bus.mem_ack = 1'b0;
    #1;
    chk("pushpop_head", bus.mem_addr, 32'h0000_0500);
    chk("pushpop_req",  32'(bus.mem_req), 32'd1);
    bus.mem_ack = 1'b1;
    tick();
    chk("pushpop_one_entry", 32'(bus.sb_empty), 32'd1);

    // Reset mid-drain with ack and a commit in the same cycle
    bus.mem_ack = 1'b0;
    bus.v = 1'b1; bus.mwe = 1'b1; bus.maddr = 32'h0000_0600; bus.mdata = 32'h0000_0066;
    tick();
    idle();
    bus.v = 1'b1; bus.rfwe = 1'b1; bus.drid = 3'd2; bus.rfval = 32'h0000_0077;
    bus.rd_id0 = 3'd2;
    bus.mem_ack = 1'b1;
    reset_n = 1'b0;
    tick();
    chk("rstmid_mem_req",  32'(bus.mem_req), 32'd0);
    chk("rstmid_sb_empty", 32'(bus.sb_empty), 32'd1);
    chk("rstmid_eip",      bus.eip, 32'h0000_FFF0);
    chk("rstmid_gpr2",     bus.rd_val0, 32'd0);
    idle();
    bus.mem_ack = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("rstmid_stall", 32'(bus.stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 2: store-buffer entries; power of two, >= 2.
REQ-002 SHALL have parameter RESET_EIP, default 32'h0000FFF0: EIP value after reset.
REQ-003 SHALL have one clock and a synchronous, active-low reset: clk in 1 is the sole clock (rising edge); reset_n in 1 is a synchronous, active-low reset.
REQ-004 SHALL have port v  in  1: writeback-stage instruction valid.
REQ-005 SHALL have ports rfwe  in  1, drid  in  3, rfval  in  32: GPR write enable, destination id, data.
REQ-006 SHALL have ports ccwe  in  32, cc  in  32: per-bit EFLAGS write mask and new flag values.
REQ-007 SHALL have ports eipwe  in  1, eipval  in  32: EIP write enable and value.
REQ-008 SHALL have ports cswe  in  1, csval  in  16: CS write enable and value.
REQ-009 SHALL have ports mwe  in  1, maddr  in  32, mdata  in  32: store request, address, data.
REQ-010 SHALL have port stall  out  1: writeback cannot commit this cycle; upstream holds.
REQ-011 SHALL have ports mem_req  out  1, mem_addr  out  32, mem_data  out  32, mem_ack  in  1: store drain handshake to memory.
REQ-012 SHALL have ports rd_id0, rd_id1  in  3 and rd_val0, rd_val1  out  32: two GPR read ports.
REQ-013 SHALL have ports eflags  out  32, eip  out  32, cs  out  16, sb_empty  out  1: architectural state and buffer-empty status.

Function
REQ-014 SHALL define commit = v & ~stall; writes occur only on a rising clk edge with commit=1.
REQ-015 SHALL drive stall = v & mwe & (store buffer full), combinationally; a same-cycle mem_ack SHALL NOT clear stall.
REQ-016 SHALL be atomic: when stall=1, no GPR, EFLAGS, EIP, CS or buffer update occurs that cycle.
REQ-017 SHALL, on commit & rfwe, write rfval to GPR[drid]; all other GPRs are unchanged.
REQ-018 SHALL, on commit, update eflags <= (eflags & ~ccwe) | (cc & ccwe), with bit 1 always forced to 1.
REQ-019 SHALL, on commit & eipwe, load eip <= eipval; on commit & cswe, load cs <= csval.
REQ-020 SHALL drive rd_val0/rd_val1 combinationally from the GPR array, with no bypass: a same-cycle write is visible next cycle.
REQ-021 SHALL implement the store buffer as a FIFO of {maddr, mdata}: push on commit & mwe, with pointers wrapping modulo SB_DEPTH.
REQ-022 SHALL assert mem_req whenever the buffer is non-empty, with mem_addr/mem_data taken from the head entry.
REQ-023 SHALL pop the head on mem_req & mem_ack; mem_ack while mem_req=0 is ignored.
REQ-024 SHALL hold mem_addr/mem_data stable while mem_req=1 and mem_ack=0.
REQ-025 SHALL, on a push into an empty buffer, assert mem_req the following cycle, giving one-cycle latency.
REQ-026 SHALL, on a simultaneous push and pop with the buffer not full, keep the occupancy unchanged and preserve FIFO order.
REQ-027 SHALL drive sb_empty = (occupancy == 0), registered-state derived.
REQ-028 SHALL set full when occupancy == SB_DEPTH; occupancy SHALL never exceed SB_DEPTH or underflow.
REQ-029 SHALL ignore all write enables when v=0, regardless of their values.

Reset
REQ-030 SHALL, while reset_n=0 at a clk edge, clear all GPRs to 0 and set eflags=32'h00000002, eip=RESET_EIP, cs=16'hF000.
REQ-031 SHALL, on reset, empty the store buffer, so that mem_req=0, sb_empty=1 and stall=0 in the cycle after reset.
REQ-032 SHALL, when reset is applied mid-drain, discard pending stores without issuing them, even if mem_ack arrives that cycle.
REQ-033 SHALL let reset take precedence over commit in the same cycle.

Verification
REQ-034 SHALL be verified with: reset, then v=1 rfwe=1 drid=3 rfval=32'hDEADBEEF -> next cycle rd_id0=3 gives 32'hDEADBEEF, and the other GPRs read 0.
REQ-035 SHALL be verified with: eflags=32'h00000002, commit with ccwe=32'h000008D5 and cc=32'hFFFFFFFF -> eflags=32'h000008D7.
REQ-036 SHALL be verified with: mem_ack held 0, two commits with mwe (A1/D1, A2/D2), then a third mwe -> stall=1 and the third instruction's rfwe does not commit; mem_addr=A1 throughout.
REQ-037 SHALL be verified with: full buffer, mem_ack=1 for one cycle -> head becomes A2 and stall drops next cycle; the held third store commits and drains after A2.
REQ-038 SHALL be verified with: v=0 with every enable asserted -> no state change and no push.
REQ-039 SHALL be verified with: one pending store and reset_n=0 in the same cycle as mem_ack -> next cycle mem_req=0, sb_empty=1, eip=32'h0000FFF0.
